// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector. Each channel synchronises an asynchronous
// input, debounces it and reports the accepted edges enabled by its mode
// as one-cycle pulses, a sticky flag and a saturating edge count.
// irq_o is the OR of all sticky flags.

// One channel: synchroniser -> debounce filter -> edge pulse / flag / counter.
module multi_edge_detector_ch #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic             flag,
    output logic [CNT_W-1:0] count
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0]    DLAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [DW-1:0]          dcnt;
    logic                   upd;
    logic                   rise_ev;
    logic                   fall_ev;
    logic                   edge_ev;

    assign s = sync[SYNC_STAGES-1];

    // Shift the raw input through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], a};
    end

    // Update event: the synced value has differed from the level long enough.
    // Mode is only looked at here, so mode changes between events do nothing.
    always_comb begin
        upd     = (s != level) && (dcnt == DLAST);
        rise_ev = upd &  s & mode[0];
        fall_ev = upd & ~s & mode[1];
        edge_ev = rise_ev | fall_ev;
    end

    // Debounce: any return to the current level restarts the persistence count.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 1'b0;
            dcnt  <= '0;
        end else if (s == level) begin
            dcnt  <= '0;
        end else if (dcnt == DLAST) begin
            level <= s;
            dcnt  <= '0;
        end else begin
            dcnt  <= dcnt + DW'(1);
        end
    end

    // Edge pulses land in the same cycle level first shows the new value.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= rise_ev;
            fall <= fall_ev;
        end
    end

    // Sticky flag and saturating counter; a same-cycle edge beats the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            flag  <= 1'b0;
            count <= '0;
        end else begin
            flag <= (flag & ~clr) | edge_ev;
            if (clr)
                count <= edge_ev ? CNT_W'(1) : '0;
            else if (edge_ev && count != CNT_MAX)
                count <= count + CNT_W'(1);
        end
    end
endmodule

// Top: N independent channels plus the combined interrupt.
module multi_edge_detector #(
    parameter int N               = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       a_i,
    input  logic [2*N-1:0]     mode_i,
    input  logic [N-1:0]       clr_i,
    output logic [N-1:0]       level_o,
    output logic [N-1:0]       rise_o,
    output logic [N-1:0]       fall_o,
    output logic [N-1:0]       flag_o,
    output logic [N*CNT_W-1:0] count_o,
    output logic               irq_o
);
    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_ch
            multi_edge_detector_ch #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_ch (
                .clk  (clk),
                .reset(reset),
                .a    (a_i[k]),
                .mode (mode_i[2*k +: 2]),
                .clr  (clr_i[k]),
                .level(level_o[k]),
                .rise (rise_o[k]),
                .fall (fall_o[k]),
                .flag (flag_o[k]),
                .count(count_o[k*CNT_W +: CNT_W])
            );
        end
    endgenerate

    // Interrupt follows the registered flags directly.
    always_comb irq_o = |flag_o;
endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench: stimulus pushes expected edge pulses (cycle + rise/fall
// vectors) into a queue; a negedge monitor pops and compares whenever any
// rise_o/fall_o bit is high. Status outputs are checked directly.
module tb_multi_edge_detector;
    localparam int N  = 4;
    localparam int SS = 2;
    localparam int DC = 4;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    a_i;
    logic [2*N-1:0]  mode_i;
    logic [N-1:0]    clr_i;
    logic [N-1:0]    level_o, rise_o, fall_o, flag_o;
    logic [N*CW-1:0] count_o;
    logic            irq_o;

    typedef struct {
        int           cyc;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    multi_edge_detector #(.N(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .a_i(a_i), .mode_i(mode_i), .clr_i(clr_i),
        .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o), .flag_o(flag_o),
        .count_o(count_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Advance n clock edges, then step just past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Input set now (just after an edge) gives a pulse visible after edge cyc+6.
    task automatic expect_pulse(input logic [N-1:0] r, input logic [N-1:0] f);
        exp_t e;
        e.cyc  = cyc + SS + DC;
        e.rise = r;
        e.fall = f;
        q.push_back(e);
    endtask

    // Monitor: every observed pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if ((rise_o | fall_o) != '0) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: rise=%b fall=%b at cycle %0d, none expected",
                         rise_o, fall_o, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                chk("pulse_rise", 32'(rise_o), 32'(e.rise));
                chk("pulse_fall", 32'(fall_o), 32'(e.fall));
            end
        end
    end

    task automatic chk_all_zero(input string nm);
        chk({nm, "_level"}, 32'(level_o), 32'h0);
        chk({nm, "_pulse"}, 32'(rise_o | fall_o), 32'h0);
        chk({nm, "_flag"},  32'(flag_o), 32'h0);
        chk({nm, "_count"}, 32'(count_o), 32'h0);
        chk({nm, "_irq"},   32'(irq_o), 32'h0);
    endtask

    initial begin
        reset  = 1'b1;
        a_i    = '0;
        clr_i  = '0;
        mode_i = {2'b01, 2'b00, 2'b11, 2'b01};   // ch3 rise, ch2 off, ch1 both, ch0 rise
        tick(3);
        chk_all_zero("reset");
        reset = 1'b0;
        tick(2);

        // ch0 rising edge, exactly SS+DC-1 edges after the input settles
        a_i[0] = 1'b1;
        expect_pulse(4'b0001, 4'b0000);
        tick(10);
        chk("ch0_level", 32'(level_o[0]), 32'h1);
        chk("ch0_flag", 32'(flag_o[0]), 32'h1);
        chk("ch0_count", 32'(count_o[0*CW +: CW]), 32'h1);
        chk("ch0_irq", 32'(irq_o), 32'h1);

        // ch1 three-cycle glitch is rejected
        a_i[1] = 1'b1;
        tick(3);
        a_i[1] = 1'b0;
        tick(10);
        chk("ch1_glitch_level", 32'(level_o[1]), 32'h0);
        chk("ch1_glitch_count", 32'(count_o[1*CW +: CW]), 32'h0);

        // ch1 six-cycle pulse: one rise then one fall
        a_i[1] = 1'b1;
        expect_pulse(4'b0010, 4'b0000);
        tick(6);
        a_i[1] = 1'b0;
        expect_pulse(4'b0000, 4'b0010);
        tick(10);
        chk("ch1_level", 32'(level_o[1]), 32'h0);
        chk("ch1_count", 32'(count_o[1*CW +: CW]), 32'h2);
        chk("ch1_flag", 32'(flag_o[1]), 32'h1);

        // ch2 mode off: level tracks, nothing else moves
        a_i[2] = 1'b1;
        tick(10);
        chk("ch2_level_hi", 32'(level_o[2]), 32'h1);
        a_i[2] = 1'b0;
        tick(10);
        chk("ch2_level_lo", 32'(level_o[2]), 32'h0);
        chk("ch2_flag", 32'(flag_o[2]), 32'h0);
        chk("ch2_count", 32'(count_o[2*CW +: CW]), 32'h0);

        // ch3 counter saturates at 3 with CNT_W=2
        for (int i = 1; i <= 5; i++) begin
            a_i[3] = 1'b1;
            expect_pulse(4'b1000, 4'b0000);
            tick(8);
            a_i[3] = 1'b0;
            tick(8);
            if (i == 3) chk("ch3_count_e3", 32'(count_o[3*CW +: CW]), 32'h3);
        end
        chk("ch3_count_sat", 32'(count_o[3*CW +: CW]), 32'h3);

        // 6th edge with clear on the very same edge -> count 1, flag kept
        a_i[3] = 1'b1;
        expect_pulse(4'b1000, 4'b0000);
        tick(5);
        clr_i[3] = 1'b1;
        tick(1);
        clr_i[3] = 1'b0;
        chk("ch3_clr_edge_count", 32'(count_o[3*CW +: CW]), 32'h1);
        chk("ch3_clr_edge_flag", 32'(flag_o[3]), 32'h1);
        tick(3);

        // plain clear of ch0, then of the rest; irq drops with the last flag
        clr_i = 4'b0001;
        tick(1);
        clr_i = '0;
        chk("ch0_clr_flag", 32'(flag_o[0]), 32'h0);
        chk("ch0_clr_count", 32'(count_o[0*CW +: CW]), 32'h0);
        chk("irq_still_set", 32'(irq_o), 32'h1);
        clr_i = 4'b1010;
        tick(1);
        clr_i = '0;
        chk("all_clr_flag", 32'(flag_o), 32'h0);
        chk("all_clr_count", 32'(count_o), 32'h0);
        chk("all_clr_irq", 32'(irq_o), 32'h0);

        // ch0 falls (fall disabled: silent), then reset lands mid-debounce
        a_i[0] = 1'b0;
        tick(10);
        chk("ch0_fall_level", 32'(level_o[0]), 32'h0);
        chk("ch0_fall_flag", 32'(flag_o[0]), 32'h0);
        a_i[0] = 1'b1;
        tick(4);                     // debounce counter now at 2
        reset = 1'b1;
        tick(1);
        chk_all_zero("mid_reset");
        tick(2);
        chk_all_zero("mid_reset_hold");
        reset = 1'b0;
        // ch0 and ch3 are high at release: both report a rise after full latency
        expect_pulse(4'b1001, 4'b0000);
        tick(10);
        chk("post_reset_level", 32'(level_o), 32'h9);
        chk("post_reset_flag", 32'(flag_o), 32'h9);
        chk("post_reset_count", 32'(count_o), 32'h41);

        tick(5);
        chk("scoreboard_empty", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
Parametrised, multi-channel successor to the single-bit edge detector. Each channel synchronises an asynchronous input, debounces it, and detects rising, falling or both edges according to a per-channel mode. Each detected edge produces a one-cycle pulse, sets a sticky flag and increments a saturating counter. A combined interrupt output serves the GPIO/button front-end of the design.

Parameters:
N, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 4, consecutive cycles a new synced value must persist before acceptance (>=1; 1 = no filtering)
CNT_W, 8, width of each per-channel edge counter (>=1)

Ports:
clk  input  1  single clock; all state on posedge
reset  input  1  synchronous, active-high reset
a_i  input  N  asynchronous raw inputs, bit k = channel k
mode_i  input  2*N  per-channel mode, bits [2k+1:2k]: 00 off, 01 rise, 10 fall, 11 both
clr_i  input  N  per-channel clear of flag and counter; one-cycle strobe, sampled every clock
level_o  output  N  debounced level per channel
rise_o  output  N  one-cycle pulse on each accepted, enabled rising edge
fall_o  output  N  one-cycle pulse on each accepted, enabled falling edge
flag_o  output  N  sticky edge-detected flag per channel
count_o  output  N*CNT_W  per-channel saturating edge count, channel k at [k*CNT_W +: CNT_W]
irq_o  output  1  OR of all flag_o bits

Behaviour:
- Reset (synchronous, active-high) zeroes all synchroniser flops, debounce counters, level_o, rise_o, fall_o, flag_o, count_o and irq_o. Reset overrides all other inputs on the same edge.
- Synchroniser: a_i[k] passes through SYNC_STAGES flops; s[k] is the last stage.
- Debounce, per channel, with registers filt = level_o and dcnt:
  - If s == filt: dcnt <= 0.
  - Else if dcnt == DEBOUNCE_CYCLES-1: update event. filt <= s, dcnt <= 0.
  - Else: dcnt <= dcnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles restarts dcnt and is never accepted.
  - Width of dcnt is clog2(DEBOUNCE_CYCLES), minimum 1.
- Edge classification at an update event: rising if s = 1, falling if s = 0. The edge is enabled when mode bit 0 is set (rise) or mode bit 1 is set (fall).
- rise_o/fall_o are registered. They are high for exactly the one cycle in which level_o first shows the new value, and only if enabled. Otherwise they are 0.
- Latency: a_i stable before clock edge E. The pulse and the new level_o appear after edge E+SYNC_STAGES+DEBOUNCE_CYCLES-1. Defaults give 5 cycles; SYNC=2, D=1 gives 2 cycles.
- Mode off (00): filtering and level_o still operate; no pulse, flag or count.
- mode_i is sampled at the update event only. A mode change between events has no retroactive effect.
- flag_o[k]: set on an enabled edge. Cleared by clr_i[k]. A simultaneous set and clear leaves the flag at 1 (set wins).
- count_o[k]: increments by 1 on an enabled edge and saturates at 2^CNT_W-1 (no wrap). clr_i[k] zeroes it. A simultaneous clear and edge gives 1.
- irq_o is the combinational OR of the registered flag_o bits.
- Channels are fully independent. Simultaneous events on different channels are all handled in the same cycle.
- Input high at reset release: level_o starts at 0, so the accepted 1 is a rising edge after the latency above. This matches the single-bit block.
- Reset asserted mid-debounce discards the pending count. No pulse is emitted.

Test Plan:
- N=4, defaults, mode=01 on ch0; a_i[0] 0->1 held -> rise_o[0] single pulse exactly 5 cycles later, flag_o[0]=1, count_o[0]=1, irq_o=1; fall_o stays 0.
- Ch1 mode=11, a_i[1] pulsed high for 3 cycles (< DEBOUNCE 4) -> no level_o change, no pulse. Then 6 cycles high then low -> one rise and one fall pulse, count_o[1]=2.
- Ch2 mode=00, toggle a_i[2] with long holds -> level_o[2] tracks, rise_o/fall_o/flag_o/count_o[2] stay 0.
- CNT_W=2, ch3 mode=01, 5 accepted rising edges -> count_o[3] stays at 3 after the 3rd edge. clr_i[3] on the same cycle as a 6th edge -> count_o[3]=1, flag_o[3]=1.
- clr_i[0] with no edge -> flag_o[0]=0, count_o[0]=0; irq_o drops once all flags are 0.
- Reset asserted while a_i[0] debounce is at dcnt=2, then released with a_i[0]=1 -> all outputs 0 during reset; rise_o[0] after full latency from release.
